// File: rtl/mmio_serial_hub.sv
// rtl/mmio_serial_hub.sv - memory-mapped decode for NUM_CH serial channels with RX FIFOs and TX holding registers
module mmio_serial_hub #(
    parameter int          NUM_CH   = 2,
    parameter logic [15:0] IO_BASE  = 16'hBF00,
    parameter int          RX_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mem_rw,
    input  logic [15:0]           addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic [15:0]           ram_addr,
    output logic                  ram_sel,
    input  logic [15:0]           ram_rdata,
    input  logic [NUM_CH-1:0]     rx_valid,
    input  logic [8*NUM_CH-1:0]   rx_data,
    output logic [NUM_CH-1:0]     tx_valid,
    output logic [8*NUM_CH-1:0]   tx_data,
    input  logic [NUM_CH-1:0]     tx_ready,
    output logic [NUM_CH-1:0]     irq
);
    localparam int          PW       = $clog2(RX_DEPTH);
    localparam int          CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] WIN_SIZE = 16'(2 * NUM_CH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(RX_DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [15:0]             offset;
    logic                    in_win;
    logic                    is_status;
    logic [NUM_CH-1:0]       sel_oh;
    logic [1:0]              prev_rw;
    logic [15:0]             prev_addr;
    logic                    rd_first;
    logic                    wr_first;
    logic [NUM_CH-1:0][7:0]  head_v;
    logic [NUM_CH-1:0][7:0]  tx_data_v;
    logic [NUM_CH-1:0]       rx_avail_v;
    logic [NUM_CH-1:0]       rx_ovf_v;
    logic [NUM_CH-1:0]       tx_ovf_v;
    logic [NUM_CH-1:0]       tx_valid_v;
    logic [NUM_CH-1:0]       irq_v;
    logic [15:0]             io_word;
    logic                    unused_wdata;

    assign offset       = addr - IO_BASE;
    assign in_win       = (addr >= IO_BASE) && (offset < WIN_SIZE);
    assign is_status    = offset[0];
    assign ram_addr     = addr;
    assign ram_sel      = !in_win;
    assign rdata        = in_win ? io_word : ram_rdata;
    assign tx_valid     = tx_valid_v;
    assign tx_data      = tx_data_v;
    assign irq          = irq_v;
    assign unused_wdata = ^wdata[15:8];

    // A read or write is acted on only in the first cycle it is presented.
    assign rd_first = (mem_rw == 2'b01) && !((prev_rw == 2'b01) && (prev_addr == addr));
    assign wr_first = (mem_rw == 2'b10) && !((prev_rw == 2'b10) && (prev_addr == addr));

    // Remember last cycle's access so held accesses are not repeated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_rw   <= 2'b00;
            prev_addr <= 16'h0000;
        end else begin
            prev_rw   <= mem_rw;
            prev_addr <= addr;
        end
    end

    // One-hot channel select for in-window addresses.
    always_comb begin
        sel_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_oh[c] = in_win && (offset[CHW:1] == CHW'(c));
        end
    end

    // Register read mux: DATA returns FIFO head, STATUS returns flag nibble.
    always_comb begin
        io_word = 16'h0000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_oh[c]) begin
                io_word = is_status ? {12'h000, tx_ovf_v[c], rx_ovf_v[c], rx_avail_v[c], !tx_valid_v[c]}
                                    : {8'h00, head_v[c]};
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]    fifo_mem [RX_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [PW:0]   count;
        logic          full;
        logic          pop;
        logic          push;
        logic          rx_ovf_set;
        logic          rx_ovf_clr;
        logic          data_wr;
        logic          hshake;
        logic          accept;
        logic          tx_ovf_set;
        logic          tx_ovf_clr;
        logic          rx_ovf_r;
        logic          tx_ovf_r;
        logic          tx_valid_r;
        logic [7:0]    tx_data_r;
        logic          irq_r;

        assign full       = (count == FULL_CNT);
        assign pop        = rd_first && sel_oh[c] && !is_status && (count != '0);
        assign push       = rx_valid[c] && (!full || pop);
        assign rx_ovf_set = rx_valid[c] && full && !pop;
        assign rx_ovf_clr = wr_first && sel_oh[c] && is_status && wdata[2];
        assign data_wr    = wr_first && sel_oh[c] && !is_status;
        assign hshake     = tx_valid_r && tx_ready[c];
        assign accept     = data_wr && (!tx_valid_r || hshake);
        assign tx_ovf_set = data_wr && !accept;
        assign tx_ovf_clr = wr_first && sel_oh[c] && is_status && wdata[3];

        assign head_v[c]     = (count != '0) ? fifo_mem[rd_ptr] : 8'h00;
        assign rx_avail_v[c] = (count != '0);
        assign rx_ovf_v[c]   = rx_ovf_r;
        assign tx_ovf_v[c]   = tx_ovf_r;
        assign tx_valid_v[c] = tx_valid_r;
        assign tx_data_v[c]  = tx_data_r;
        assign irq_v[c]      = irq_r;

        // FIFO storage carries no reset; emptiness is tracked by count.
        always_ff @(posedge clk) begin
            if (push) begin
                fifo_mem[wr_ptr] <= rx_data[8*c +: 8];
            end
        end

        // Channel state: FIFO pointers, sticky errors, TX holding register, irq.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                rx_ovf_r   <= 1'b0;
                tx_ovf_r   <= 1'b0;
                tx_valid_r <= 1'b0;
                tx_data_r  <= 8'h00;
                irq_r      <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                if (rx_ovf_set) begin
                    rx_ovf_r <= 1'b1;
                end else if (rx_ovf_clr) begin
                    rx_ovf_r <= 1'b0;
                end
                if (tx_ovf_set) begin
                    tx_ovf_r <= 1'b1;
                end else if (tx_ovf_clr) begin
                    tx_ovf_r <= 1'b0;
                end
                if (accept) begin
                    tx_data_r  <= wdata[7:0];
                    tx_valid_r <= 1'b1;
                end else if (hshake) begin
                    tx_valid_r <= 1'b0;
                end
                irq_r <= (count != '0) || rx_ovf_r || tx_ovf_r;
            end
        end
    end
endmodule

// File: tb/tb_mmio_serial_hub.sv
// tb/tb_mmio_serial_hub.sv - scoreboard bench for mmio_serial_hub
module tb_mmio_serial_hub;
    localparam int K_RDATA = 0;
    localparam int K_RSEL  = 1;
    localparam int K_RADDR = 2;
    localparam int K_TXV   = 3;
    localparam int K_TXD   = 4;
    localparam int K_IRQ   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mem_rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] ram_addr;
    logic        ram_sel;
    logic [15:0] ram_rdata;
    logic [1:0]  rx_valid;
    logic [15:0] rx_data;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_ready;
    logic [1:0]  irq;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mmio_serial_hub dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rw    (mem_rw),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_rdata (ram_rdata),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_RDATA: return rdata;
            K_RSEL:  return {15'h0, ram_sel};
            K_RADDR: return ram_addr;
            K_TXV:   return {14'h0, tx_valid};
            K_TXD:   return tx_data;
            default: return {14'h0, irq};
        endcase
    endfunction

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = observe(e.kind);
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic chk(input string n, input int k, input logic [15:0] v);
        exp_q.push_back('{n, k, v});
    endtask

    task automatic step(input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        mem_rw   = rw;
        addr     = a;
        wdata    = d;
        rx_valid = 2'b00;
    endtask

    task automatic push_rx(input int ch, input logic [7:0] b);
        step(2'b00, 16'h0000, 16'h0000);
        rx_valid[ch]       = 1'b1;
        rx_data[8*ch +: 8] = b;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] v, input string n);
        step(2'b01, a, 16'h0000);
        chk(n, K_RDATA, v);
        step(2'b00, 16'h0000, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        step(2'b10, a, d);
        step(2'b00, 16'h0000, 16'h0000);
    endtask

    initial begin
        logic [15:0] drain_exp [8];
        drain_exp = '{16'h0081, 16'h0082, 16'h0083, 16'h0084,
                      16'h0085, 16'h0086, 16'h0087, 16'h0099};
        mem_rw    = 2'b00;
        addr      = 16'h0000;
        wdata     = 16'h0000;
        ram_rdata = 16'hBEEF;
        rx_valid  = 2'b00;
        rx_data   = 16'h0000;
        tx_ready  = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        step(2'b00, 16'hBF01, 16'h0000);
        chk("reset_status", K_RDATA, 16'h0001);
        chk("reset_ramsel", K_RSEL, 16'h0000);
        chk("reset_txv", K_TXV, 16'h0000);
        chk("reset_txd", K_TXD, 16'h0000);
        chk("reset_irq", K_IRQ, 16'h0000);

        // Passthrough and window edges
        step(2'b01, 16'h1234, 16'h0000);
        chk("pass_ramsel", K_RSEL, 16'h0001);
        chk("pass_rdata", K_RDATA, 16'hBEEF);
        chk("pass_ramaddr", K_RADDR, 16'h1234);
        step(2'b00, 16'hBF00, 16'h0000);
        chk("win_bf00_sel", K_RSEL, 16'h0000);
        chk("win_bf00_data", K_RDATA, 16'h0000);
        step(2'b00, 16'hBF04, 16'h0000);
        chk("win_bf04_sel", K_RSEL, 16'h0001);
        step(2'b00, 16'hBEFF, 16'h0000);
        chk("win_beff_sel", K_RSEL, 16'h0001);
        step(2'b00, 16'hBF03, 16'h0000);
        chk("win_bf03_sel", K_RSEL, 16'h0000);

        // RX path on channel 1
        push_rx(1, 8'h41);
        push_rx(1, 8'h42);
        step(2'b01, 16'hBF03, 16'h0000);
        chk("ch1_status2", K_RDATA, 16'h0003);
        chk("ch1_irq", K_IRQ, 16'h0002);
        step(2'b00, 16'h0000, 16'h0000);
        rd(16'hBF02, 16'h0041, "ch1_pop1");
        rd(16'hBF02, 16'h0042, "ch1_pop2");
        rd(16'hBF03, 16'h0001, "ch1_status0");
        rd(16'hBF02, 16'h0000, "ch1_empty");
        chk("ch1_irq_clear", K_IRQ, 16'h0000);

        // Held read pops once
        push_rx(0, 8'h11);
        push_rx(0, 8'h22);
        step(2'b01, 16'hBF00, 16'h0000);
        chk("held_first", K_RDATA, 16'h0011);
        step(2'b01, 16'hBF00, 16'h0000);
        step(2'b01, 16'hBF00, 16'h0000);
        step(2'b01, 16'hBF00, 16'h0000);
        chk("held_last", K_RDATA, 16'h0022);
        step(2'b00, 16'h0000, 16'h0000);
        rd(16'hBF01, 16'h0003, "held_status");
        rd(16'hBF00, 16'h0022, "held_next");
        rd(16'hBF01, 16'h0001, "held_drained");

        // RX overflow, W1C and pop+push while full
        for (int i = 0; i < 9; i++) push_rx(0, 8'h80 + 8'(i));
        step(2'b01, 16'hBF01, 16'h0000);
        chk("ovf_status", K_RDATA, 16'h0007);
        chk("ovf_irq", K_IRQ, 16'h0001);
        step(2'b00, 16'h0000, 16'h0000);
        wr(16'hBF01, 16'h0004);
        rd(16'hBF01, 16'h0003, "ovf_w1c");
        step(2'b01, 16'hBF00, 16'h0000);
        rx_valid[0]  = 1'b1;
        rx_data[7:0] = 8'h99;
        chk("full_pop_head", K_RDATA, 16'h0080);
        step(2'b00, 16'h0000, 16'h0000);
        rd(16'hBF01, 16'h0003, "full_pushpop_no_ovf");
        for (int i = 0; i < 8; i++) rd(16'hBF00, drain_exp[i], $sformatf("drain%0d", i));
        rd(16'hBF01, 16'h0001, "drain_status");

        // TX holding register
        step(2'b10, 16'hBF00, 16'h0155);
        step(2'b00, 16'h0000, 16'h0000);
        chk("tx_valid1", K_TXV, 16'h0001);
        chk("tx_data1", K_TXD, 16'h0055);
        rd(16'hBF01, 16'h0000, "tx_busy_status");
        step(2'b10, 16'hBF00, 16'h0066);
        step(2'b00, 16'h0000, 16'h0000);
        chk("tx_drop_data", K_TXD, 16'h0055);
        step(2'b01, 16'hBF01, 16'h0000);
        chk("tx_ovf_status", K_RDATA, 16'h0008);
        chk("tx_ovf_irq", K_IRQ, 16'h0001);
        step(2'b00, 16'h0000, 16'h0000);
        step(2'b10, 16'hBF00, 16'h0077);
        tx_ready = 2'b01;
        step(2'b00, 16'h0000, 16'h0000);
        tx_ready = 2'b00;
        chk("tx_hs_valid", K_TXV, 16'h0001);
        chk("tx_hs_data", K_TXD, 16'h0077);
        step(2'b00, 16'h0000, 16'h0000);
        tx_ready = 2'b01;
        step(2'b00, 16'h0000, 16'h0000);
        tx_ready = 2'b00;
        chk("tx_drained", K_TXV, 16'h0000);
        rd(16'hBF01, 16'h0009, "tx_ovf_sticky");
        wr(16'hBF01, 16'h0008);
        rd(16'hBF01, 16'h0001, "tx_ovf_w1c");
        step(2'b10, 16'hBF02, 16'h01AB);
        step(2'b00, 16'h0000, 16'h0000);
        chk("tx_ch1_data", K_TXD, 16'hAB77);
        chk("tx_ch1_valid", K_TXV, 16'h0002);

        // Asynchronous reset mid-read with FIFO half full
        for (int i = 0; i < 4; i++) push_rx(0, 8'h01 + 8'(i));
        step(2'b01, 16'hBF00, 16'h0000);
        #2 rst = 1'b0;
        chk("rst_rdata", K_RDATA, 16'h0000);
        chk("rst_txv", K_TXV, 16'h0000);
        chk("rst_txd", K_TXD, 16'h0000);
        chk("rst_irq", K_IRQ, 16'h0000);
        step(2'b01, 16'hBF00, 16'h0000);
        rst = 1'b1;
        chk("rst_release_read", K_RDATA, 16'h0000);
        step(2'b00, 16'h0000, 16'h0000);
        rd(16'hBF01, 16'h0001, "rst_status");
        push_rx(0, 8'h5A);
        rd(16'hBF00, 16'h005A, "rst_new_data");
        rd(16'hBF01, 16'h0001, "rst_final_status");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
